// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit 7-segment display.
// A loaded BCD count is parked in a shadow register and copied into the
// display register only while idle or at a frame boundary, so one frame
// always shows a single, consistent count. Every output is a register.
module disp_scan_ctrl #(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GAP      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic              blank_lz,
  output logic [3:0]        digit_code,
  output logic [NDIG-1:0]   digit_en,
  output logic              upd_done,
  output logic              pending
);

  localparam int unsigned DivMax = (SCAN_DIV > GAP) ? SCAN_DIV : GAP;
  localparam int unsigned DivW   = (DivMax > 1) ? $clog2(DivMax) : 1;
  localparam int unsigned IdxW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [DivW-1:0] ScanLast = DivW'(SCAN_DIV - 1);
  // Unused when GAP is 0: the gap state is then unreachable.
  localparam logic [DivW-1:0] GapLast  = (GAP > 0) ? DivW'(GAP - 1) : '0;
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NDIG - 1);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [4*NDIG-1:0] shadow_q;
  logic [4*NDIG-1:0] disp_q, disp_d;
  logic              transfer;
  logic              step;
  logic              lz;
  logic [NDIG-1:0]   zero_above;
  logic [NDIG-1:0]   en_d;
  logic [3:0]        code_d;

  // Next state of the scan sequencer and the frame-boundary transfer decision.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    div_d    = div_q;
    transfer = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending) begin
          transfer = 1'b1;
          state_d  = StScan;
          idx_d    = '0;
          div_d    = '0;
        end
      end
      StScan: begin
        if (div_q == ScanLast) begin
          div_d = '0;
          if (GAP > 0) begin
            state_d = StGap;
          end else begin
            step = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if (div_q == GapLast) begin
          div_d   = '0;
          state_d = StScan;
          step    = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Moving past the last digit is the frame boundary.
    if (step) begin
      if (idx_q == IdxLast) begin
        idx_d    = '0;
        transfer = pending;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Display contents as they will be after this edge.
  always_comb begin
    disp_d = transfer ? shadow_q : disp_q;
  end

  // Registered-output values: leading-zero mask, one-hot enable and digit code
  // for the state being entered, so the outputs switch on the entering edge.
  always_comb begin
    lz         = 1'b1;
    zero_above = '0;
    for (int i = int'(NDIG) - 1; i >= 0; i--) begin
      if (disp_d[4*i +: 4] != 4'd0) begin
        lz = 1'b0;
      end
      zero_above[i] = lz;
    end
    en_d   = '0;
    code_d = digit_code;
    if (state_d == StScan) begin
      for (int i = 0; i < int'(NDIG); i++) begin
        if (idx_d == IdxW'(i)) begin
          code_d = disp_d[4*i +: 4];
          // Digit 0 is never blanked so a zero count still shows "0".
          if (i == 0 || !blank_lz || !zero_above[i]) begin
            en_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // State, buffers and all outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      div_q      <= '0;
      shadow_q   <= '0;
      disp_q     <= '0;
      pending    <= 1'b0;
      upd_done   <= 1'b0;
      digit_en   <= '0;
      digit_code <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      disp_q     <= disp_d;
      upd_done   <= transfer;
      digit_en   <= en_d;
      digit_code <= code_d;
      // A load coinciding with a transfer keeps pending set for the new count.
      if (load) begin
        shadow_q <= bcd_in;
        pending  <= 1'b1;
      end else if (transfer) begin
        pending  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with NDIG=4, SCAN_DIV=4, GAP=1 (20-cycle frame).
module tb_disp_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_lz;
  logic [3:0]  digit_code;
  logic [3:0]  digit_en;
  logic        upd_done;
  logic        pending;

  int n_assert = 0;
  int n_fail   = 0;

  disp_scan_ctrl #(
    .NDIG    (4),
    .SCAN_DIV(4),
    .GAP     (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .bcd_in    (bcd_in),
    .blank_lz  (blank_lz),
    .digit_code(digit_code),
    .digit_en  (digit_en),
    .upd_done  (upd_done),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Check one 20-cycle frame showing val, starting at frame cycle 0.
  // Up to two loads (cycle l1/l2, -1 = none) are strobed during the frame.
  task automatic check_frame(input logic [15:0] val, input logic blank, input logic exp_upd,
                             input logic pend0, input int l1, input logic [15:0] v1,
                             input int l2, input logic [15:0] v2);
    int          first_l;
    int          slot;
    int          w;
    logic [15:0] sh;
    logic        lit;
    logic [3:0]  en_e;
    logic        pend_e;
    first_l = (l1 >= 0) ? l1 : 100;
    if (l2 >= 0 && l2 < first_l) first_l = l2;
    blank_lz = blank;
    for (int c = 0; c < 20; c++) begin
      slot   = c / 5;
      w      = c % 5;
      sh     = val >> (4 * slot);
      lit    = (slot == 0) || !blank || (sh != 16'd0);
      en_e   = (w < 4 && lit) ? 4'(1 << slot) : 4'd0;
      pend_e = pend0 || (c > first_l);
      chk("digit_en", 32'(digit_en), 32'(en_e));
      chk("digit_code", 32'(digit_code), 32'(sh[3:0]));
      chk("upd_done", 32'(upd_done), (c == 0) ? 32'(exp_upd) : 32'd0);
      chk("pending", 32'(pending), 32'(pend_e));
      if (c == l1) begin
        load   = 1'b1;
        bcd_in = v1;
      end
      if (c == l2) begin
        load   = 1'b1;
        bcd_in = v2;
      end
      tick();
      load = 1'b0;
    end
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    bcd_in   = 16'h0000;
    blank_lz = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_en", 32'(digit_en), 32'd0);
    chk("rst_code", 32'(digit_code), 32'd0);
    chk("rst_upd", 32'(upd_done), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    tick();
    chk("idle_en", 32'(digit_en), 32'd0);

    // 1: load from idle, upd_done on the next cycle, then two identical frames.
    load   = 1'b1;
    bcd_in = 16'h1234;
    tick();
    load = 1'b0;
    chk("ld_pending", 32'(pending), 32'd1);
    chk("ld_upd", 32'(upd_done), 32'd0);
    chk("ld_en", 32'(digit_en), 32'd0);
    tick();
    check_frame(16'h1234, 1'b0, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);
    // 2: leading-zero blanking; load 0050 here, shown next frame.
    check_frame(16'h1234, 1'b1, 1'b0, 1'b0, 0, 16'h0050, -1, 16'h0);
    check_frame(16'h0050, 1'b1, 1'b1, 1'b0, 0, 16'h0000, -1, 16'h0);
    check_frame(16'h0000, 1'b1, 1'b1, 1'b0, 0, 16'h5678, -1, 16'h0);
    // 3: load while digit 1 is lit; rest of frame keeps old value.
    check_frame(16'h5678, 1'b0, 1'b1, 1'b0, 6, 16'h9999, -1, 16'h0);
    // 4: two loads in one frame; only the newest is shown.
    check_frame(16'h9999, 1'b0, 1'b1, 1'b0, 2, 16'h1111, 12, 16'h2222);
    // 5: load on the exact transfer cycle of a pending count.
    check_frame(16'h2222, 1'b0, 1'b1, 1'b0, 3, 16'h2222, 19, 16'h3333);
    check_frame(16'h2222, 1'b0, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
    check_frame(16'h3333, 1'b0, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

    // 6: asynchronous reset mid-scan with a load pending.
    chk("pre_rst_en", 32'(digit_en), 32'd1);
    chk("pre_rst_code", 32'(digit_code), 32'd3);
    load   = 1'b1;
    bcd_in = 16'h4444;
    tick();
    load = 1'b0;
    chk("pre_rst_pending", 32'(pending), 32'd1);
    chk("pre_rst_en1", 32'(digit_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_en", 32'(digit_en), 32'd0);
    chk("async_code", 32'(digit_code), 32'd0);
    chk("async_pending", 32'(pending), 32'd0);
    chk("async_upd", 32'(upd_done), 32'd0);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_en", 32'(digit_en), 32'd0);
      chk("post_rst_upd", 32'(upd_done), 32'd0);
    end
    // Hex codes pass through unmodified.
    load   = 1'b1;
    bcd_in = 16'h00A5;
    tick();
    load = 1'b0;
    chk("reload_pending", 32'(pending), 32'd1);
    chk("reload_en", 32'(digit_en), 32'd0);
    tick();
    check_frame(16'h00A5, 1'b0, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
